// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, register offsets and scan FSM encoding for the FFT peak detector
package fft_pkg;
  localparam int DW = 16;
  localparam int NBINS = 16;
  localparam logic [3:0] LAST_BIN = 4'(NBINS - 1);
  localparam logic [1:0] CTRL_OFS = 2'd0;
  localparam logic [1:0] PEAK_BIN_OFS = 2'd1;
  localparam logic [1:0] PEAK_MAG_LO_OFS = 2'd2;
  localparam logic [1:0] PEAK_MAG_HI_OFS = 2'd3;
  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN} state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: combinational re^2 + im^2 of one signed complex sample, unsigned result
//   re, im : signed DW-bit components
//   mag    : unsigned 2*DW-bit magnitude squared; (-2^15,-2^15) gives exactly 2^31
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic signed [DW-1:0]   re,
  input  logic signed [DW-1:0]   im,
  output logic        [2*DW-1:0] mag
);
  logic signed [2*DW-1:0] re_sq, im_sq;
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign mag = re_sq + im_sq;
endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: snapshots 16 FFT bins on a software start and serially finds the largest |X|^2
//   mclk, puc_rst     : clock, synchronous active-high reset
//   fft_re, fft_im    : flattened FFT outputs, bin k at [16k+15:16k]
//   per_addr/din/en/we: MSP430 peripheral bus; per_dout is combinational read data
//   irq_done          : one-cycle completion pulse when irq_en is set
//   FFT_PEAK_SKIP_DC_EN: when defined, bin 0 is excluded from the scan
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h0a8
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic [NBINS*DW-1:0] fft_re,
  input  logic [NBINS*DW-1:0] fft_im,
  input  logic [13:0]         per_addr,
  input  logic [15:0]         per_din,
  input  logic                per_en,
  input  logic [1:0]          per_we,
  output logic [15:0]         per_dout,
  output logic                irq_done
);
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam logic [3:0] FIRST_BIN = 4'd1;
`else
  localparam logic [3:0] FIRST_BIN = 4'd0;
`endif
  state_t state;
  logic [NBINS*DW-1:0] re_q, im_q;
  logic [3:0] idx, peak_bin;
  logic [2*DW-1:0] peak_mag, mag;
  logic busy, done, irq_en;
  logic [13:0] ofs;
  logic hit, rd, ctrl_wr;
  logic unused_din;
  assign ofs = per_addr - BASE_ADDR;
  assign hit = ofs[13:2] == 12'd0;
  assign rd = per_en & (per_we == 2'b00) & hit;
  assign ctrl_wr = per_en & (per_we == 2'b11) & hit & (ofs[1:0] == CTRL_OFS);
  assign unused_din = ^per_din[15:2];
  fft_mag_sq u_mag (
    .re (re_q[idx*DW +: DW]),
    .im (im_q[idx*DW +: DW]),
    .mag(mag)
  );
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state <= IDLE;
      re_q <= '0;
      im_q <= '0;
      idx <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      irq_en <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      irq_done <= 1'b0;
      if (ctrl_wr) irq_en <= per_din[1];
      case (state)
        IDLE: if (ctrl_wr && per_din[0]) begin
          busy <= 1'b1;
          done <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          re_q <= fft_re;
          im_q <= fft_im;
          peak_mag <= '0;
          peak_bin <= '0;
          idx <= FIRST_BIN;
          state <= SCAN;
        end
        SCAN: begin
          if (idx == FIRST_BIN || mag > peak_mag) begin
            peak_mag <= mag;
            peak_bin <= idx;
          end
          idx <= idx + 4'd1;
          if (idx == LAST_BIN) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            irq_done <= irq_en;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign per_dout = !rd ? 16'h0000 :
                    ofs[1:0] == CTRL_OFS        ? {13'b0, done, irq_en, busy} :
                    ofs[1:0] == PEAK_BIN_OFS    ? {12'b0, peak_bin} :
                    ofs[1:0] == PEAK_MAG_LO_OFS ? peak_mag[15:0] : peak_mag[31:16];
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: table-driven and sequence checks of the FFT peak detector
module tb_fft_peak_detect;
  localparam logic [13:0] BASE = 14'h0a8;
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 17;
`endif
  logic mclk = 1'b0, puc_rst = 1'b1;
  logic [255:0] fft_re = '0, fft_im = '0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic per_en = 1'b0;
  logic [1:0] per_we = 2'b00;
  logic [15:0] per_dout;
  logic irq_done;
  int checks = 0, errors = 0;
  typedef struct {
    logic [255:0] re, im;
    logic ie;
    logic [3:0] bin;
    logic [31:0] mag;
  } vec_t;
  vec_t tv[6];
  fft_peak_detect #(.BASE_ADDR(BASE)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .fft_re(fft_re), .fft_im(fft_im),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .irq_done(irq_done)
  );
  always #5 mclk = ~mclk;
  function automatic logic [255:0] put(logic [255:0] b, int k, logic [15:0] v);
    b[16*k +: 16] = v;
    return b;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  task automatic rd(input logic [1:0] o, output logic [15:0] d);
    per_en = 1'b1;
    per_we = 2'b00;
    per_addr = BASE + 14'(o);
    #1 d = per_dout;
    per_en = 1'b0;
  endtask
  task automatic wr(input logic [1:0] o, input logic [15:0] d, input logic [1:0] we);
    per_en = 1'b1;
    per_we = we;
    per_addr = BASE + 14'(o);
    per_din = d;
    @(posedge mclk);
    #1 per_en = 1'b0;
    per_we = 2'b00;
  endtask
  task automatic res(input string n, input logic [15:0] e_ctrl, input logic [3:0] e_bin, input logic [31:0] e_mag);
    logic [15:0] d;
    rd(0, d); chk({n, " ctrl"}, 32'(d), 32'(e_ctrl));
    rd(1, d); chk({n, " peak_bin"}, 32'(d), 32'(e_bin));
    rd(2, d); chk({n, " mag_lo"}, 32'(d), 32'(e_mag[15:0]));
    rd(3, d); chk({n, " mag_hi"}, 32'(d), 32'(e_mag[31:16]));
  endtask
  task automatic run(input int inj, input int rc, output int nb, output int ni, output int at);
    logic [15:0] d;
    nb = 0; ni = 0; at = 0;
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c > 0) begin
        if (c == inj) begin
          fft_re = tv[2].re;
          fft_im = tv[2].im;
          per_en = 1'b1; per_we = 2'b11; per_addr = BASE; per_din = 16'h0003;
        end
        puc_rst = (c == rc);
        @(posedge mclk);
        #1 per_en = 1'b0;
        per_we = 2'b00;
        puc_rst = 1'b0;
      end
      rd(0, d);
      nb += int'(d[0]);
      if (irq_done) begin ni++; at = c; end
    end
  endtask
  initial begin
    logic [15:0] d;
    int nb, ni, at;
    tv[0] = '{re: '0, im: '0, ie: 1'b0, bin: 4'd0, mag: 32'd0};
`ifdef FFT_PEAK_SKIP_DC_EN
    tv[0].bin = 4'd1;
`endif
    tv[1] = '{re: put({16{16'h0001}}, 5, 16'd100), im: put({16{16'h0001}}, 5, 16'hFF38), ie: 1'b0, bin: 4'd5, mag: 32'd50000};
    tv[2] = '{re: put(put('0, 3, 16'd300), 9, 16'd300), im: put(put('0, 3, 16'd400), 9, 16'd400), ie: 1'b0, bin: 4'd3, mag: 32'd250000};
    tv[3] = '{re: put('0, 12, 16'h8000), im: put('0, 12, 16'h8000), ie: 1'b1, bin: 4'd12, mag: 32'h8000_0000};
    tv[4] = '{re: '0, im: put('0, 15, 16'hFFFB), ie: 1'b0, bin: 4'd15, mag: 32'd25};
`ifdef FFT_PEAK_SKIP_DC_EN
    tv[5] = '{re: put(put('0, 0, 16'd1000), 2, 16'd10), im: '0, ie: 1'b0, bin: 4'd2, mag: 32'd100};
`else
    tv[5] = '{re: put(put('0, 0, 16'd1000), 2, 16'd10), im: '0, ie: 1'b0, bin: 4'd0, mag: 32'd1000000};
`endif
    repeat (2) @(posedge mclk);
    #1 puc_rst = 1'b0;
    res("reset", 16'h0000, 4'd0, 32'd0);
    chk("reset irq", 32'(irq_done), 32'd0);
    wr(0, 16'h0003, 2'b01);
    res("partial write", 16'h0000, 4'd0, 32'd0);
    for (int v = 0; v < 6; v++) begin
      string n;
      n = $sformatf("vec%0d", v);
      fft_re = tv[v].re;
      fft_im = tv[v].im;
      wr(0, {14'b0, tv[v].ie, 1'b1}, 2'b11);
      run(-1, -1, nb, ni, at);
      chk({n, " busy_cycles"}, 32'(nb), 32'(LAT));
      chk({n, " irq_count"}, 32'(ni), {31'b0, tv[v].ie});
      if (tv[v].ie) chk({n, " irq_cycle"}, 32'(at), 32'(LAT));
      res(n, tv[v].ie ? 16'h0006 : 16'h0004, tv[v].bin, tv[v].mag);
      if (v == 1) begin
        per_en = 1'b0;
        per_addr = BASE + 14'd2;
        #1 chk("idle bus dout", 32'(per_dout), 32'd0);
      end
    end
    wr(0, 16'h0000, 2'b11);
    fft_re = tv[1].re;
    fft_im = tv[1].im;
    wr(0, 16'h0001, 2'b11);
    run(5, -1, nb, ni, at);
    chk("busy restart busy_cycles", 32'(nb), 32'(LAT));
    chk("busy restart irq_count", 32'(ni), 32'd1);
    chk("busy restart irq_cycle", 32'(at), 32'(LAT));
    res("busy restart", 16'h0006, 4'd5, 32'd50000);
    fft_re = tv[3].re;
    fft_im = tv[3].im;
    wr(0, 16'h0003, 2'b11);
    run(-1, 8, nb, ni, at);
    chk("reset mid busy_cycles", 32'(nb), 32'd8);
    chk("reset mid irq_count", 32'(ni), 32'd0);
    res("reset mid", 16'h0000, 4'd0, 32'd0);
    fft_re = tv[2].re;
    fft_im = tv[2].im;
    wr(0, 16'h0001, 2'b11);
    repeat (LAT - 1) @(posedge mclk);
    #1 wr(0, 16'h0001, 2'b11);
    res("end collide", 16'h0004, 4'd3, 32'd250000);
    @(posedge mclk);
    #1 rd(0, d);
    chk("end collide after", 32'(d), 32'h0004);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
